// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the per-state strobe decode used by the controller.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12,
        S_BUS_ERR  = 4'd13
    } state_t;

    // Moore part of the datapath strobes; the FETCH-time ir_write/pc_write
    // depend on mem_ready and are formed in the controller itself.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal_op;
    } strobes_t;

    function automatic strobes_t decode_strobes(input state_t s);
        strobes_t d;
        d = '0;
        case (s)
            S_FETCH: begin
                d.mem_read  = 1'b1;
                d.i_or_d    = 1'b0;
                d.alu_src_a = 1'b0;
                d.alu_src_b = SRCB_FOUR;
                d.alu_op    = ALUOP_ADD;
                d.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                d.alu_src_a = 1'b0;
                d.alu_src_b = SRCB_IMM_SH2;
                d.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = SRCB_IMM;
                d.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                d.mem_read = 1'b1;
                d.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                d.reg_write  = 1'b1;
                d.mem_to_reg = 1'b1;
                d.reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                d.mem_write = 1'b1;
                d.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = SRCB_RT;
                d.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                d.reg_dst   = 1'b1;
                d.reg_write = 1'b1;
            end
            S_WB_I: begin
                d.reg_write = 1'b1;
            end
            S_BRANCH: begin
                d.alu_src_a     = 1'b1;
                d.alu_src_b     = SRCB_RT;
                d.alu_op        = ALUOP_SUB;
                d.pc_write_cond = 1'b1;
                d.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                d.pc_write  = 1'b1;
                d.pc_source = PCSRC_JUMP;
            end
            S_TRAP: begin
                d.illegal_op = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts stall cycles while a memory state waits on mem_ready and flags a
// timeout once the count has reached MAX_WAIT with memory still not ready.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count;

    // A state change always restarts the count, so each memory access gets its own budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waiting && (count != LIMIT)) begin
            count <= count + WAIT_W'(1);
        end
    end

    assign timeout = (MAX_WAIT != 0) && waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared-datapath strobes, with a memory stall timeout.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                illegal_op,
    output logic                bus_error,
    output logic [3:0]          state
);

    state_t   state_q;
    state_t   next_state;
    strobes_t strobes_q;
    strobes_t live;
    logic     bus_error_q;
    logic     in_mem_state;
    logic     waiting;
    logic     leaving;
    logic     timeout;

    // The branch decision is made by the datapath gating pc_write_cond with zero.
    logic     unused_zero;
    assign unused_zero = zero;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign waiting      = in_mem_state && !mem_ready;
    assign leaving      = (next_state != state_q);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (leaving),
        .waiting (waiting),
        .timeout (timeout)
    );

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_BUS_ERR;
            end
            S_DECODE: begin
                if ((opcode == OPCODE_W'(OP_LW)) || (opcode == OPCODE_W'(OP_SW)))
                    next_state = S_MEM_ADDR;
                else if (opcode == OPCODE_W'(OP_R))    next_state = S_EXEC_R;
                else if (opcode == OPCODE_W'(OP_ADDI)) next_state = S_EXEC_I;
                else if (opcode == OPCODE_W'(OP_BEQ))  next_state = S_BRANCH;
                else if (opcode == OPCODE_W'(OP_J))    next_state = S_JUMP;
                else                                   next_state = S_TRAP;
            end
            S_MEM_ADDR: begin
                next_state = (opcode == OPCODE_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready)    next_state = S_WB_MEM;
                else if (timeout) next_state = S_BUS_ERR;
            end
            S_MEM_WR: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_BUS_ERR;
            end
            S_EXEC_R:  next_state = S_WB_R;
            S_EXEC_I:  next_state = S_WB_I;
            S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_TRAP:
                       next_state = S_FETCH;
            S_BUS_ERR: next_state = S_BUS_ERR;
            default:   next_state = S_FETCH;
        endcase
    end

    // Strobes are registered from the next state; the reset value is FETCH's
    // decode so the first cycle after reset already issues the fetch read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            strobes_q   <= decode_strobes(S_FETCH);
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= next_state;
            strobes_q   <= decode_strobes(next_state);
            bus_error_q <= bus_error_q || (next_state == S_BUS_ERR);
        end
    end

    assign live = reset ? '0 : strobes_q;

    assign mem_read      = live.mem_read;
    assign mem_write     = live.mem_write;
    assign i_or_d        = live.i_or_d;
    assign ir_write      = !reset && (state_q == S_FETCH) && mem_ready;
    assign pc_write      = live.pc_write || ir_write;
    assign pc_write_cond = live.pc_write_cond;
    assign pc_source     = live.pc_source;
    assign alu_op        = ALUOP_W'(live.alu_op);
    assign alu_src_a     = live.alu_src_a;
    assign alu_src_b     = live.alu_src_b;
    assign reg_dst       = live.reg_dst;
    assign reg_write     = live.reg_write;
    assign mem_to_reg    = live.mem_to_reg;
    assign illegal_op    = live.illegal_op;
    assign bus_error     = bus_error_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a per-instruction reference model
// queues the expected per-cycle outputs and a monitor compares them on negedges.
module tb_multicycle_control_unit;

    localparam int TB_MAX_WAIT = 3;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal_op;
        logic       bus_error;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       alu_src_a, reg_dst, reg_write, mem_to_reg, illegal_op, bus_error;
    logic [3:0] state;

    int   checks;
    int   errors;
    int   popped;
    obs_t sb[$];

    multicycle_control_unit #(
        .OPCODE_W (6),
        .ALUOP_W  (2),
        .MAX_WAIT (TB_MAX_WAIT),
        .WAIT_W   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal_op    (illegal_op),
        .bus_error     (bus_error),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle, straight from the per-state strobe table.
    function automatic obs_t exp_obs(input int st, input logic rdy);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0: begin
                o.mem_read = 1; o.alu_src_b = 2'b01;
                o.ir_write = rdy; o.pc_write = rdy;
            end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.i_or_d = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.mem_write = 1; o.i_or_d = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_dst = 1; o.reg_write = 1; end
            8:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            9:  o.reg_write = 1;
            10: begin
                o.alu_src_a = 1; o.alu_op = 2'b01;
                o.pc_write_cond = 1; o.pc_source = 2'b01;
            end
            11: begin o.pc_write = 1; o.pc_source = 2'b10; end
            12: o.illegal_op = 1;
            13: o.bus_error = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.st = state;
        o.mem_read = mem_read; o.mem_write = mem_write; o.i_or_d = i_or_d;
        o.ir_write = ir_write; o.pc_write = pc_write; o.pc_write_cond = pc_write_cond;
        o.pc_source = pc_source; o.alu_op = alu_op; o.alu_src_a = alu_src_a;
        o.alu_src_b = alu_src_b; o.reg_dst = reg_dst; o.reg_write = reg_write;
        o.mem_to_reg = mem_to_reg; o.illegal_op = illegal_op; o.bus_error = bus_error;
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     name, got, exp, got.st, exp.st);
        end
    endtask

    // Monitor: each negedge with a pending expectation compares the DUT against it.
    initial begin
        popped = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                obs_t e;
                e = sb.pop_front();
                checkOutput($sformatf("cycle_%0d", popped), sample_dut(), e);
                popped++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_cycle(input int st, input logic rdy);
        mem_ready = rdy;
        zero = 1'($urandom_range(0, 1));
        sb.push_back(exp_obs(st, rdy));
        @(posedge clk);
        #1;
    endtask

    // A memory access stalled w cycles; past the budget the model predicts a bus error.
    task automatic mem_phase(input int st, input int w, output bit err);
        int n;
        n   = (w > TB_MAX_WAIT) ? TB_MAX_WAIT + 1 : w;
        err = (w > TB_MAX_WAIT);
        for (int i = 0; i < n; i++) drive_cycle(st, 1'b0);
        if (!err) drive_cycle(st, 1'b1);
    endtask

    task automatic async_reset(input string tag);
        mem_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput({tag, "_async_reset"}, sample_dut(), '0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_reset_held"}, sample_dut(), '0);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input int wf, input int wm);
        bit err;
        opcode = op;
        mem_phase(0, wf, err);
        if (!err) begin
            drive_cycle(1, 1'($urandom_range(0, 1)));
            case (op)
                T_LW: begin
                    drive_cycle(2, 1'($urandom_range(0, 1)));
                    mem_phase(3, wm, err);
                    if (!err) drive_cycle(4, 1'($urandom_range(0, 1)));
                end
                T_SW: begin
                    drive_cycle(2, 1'($urandom_range(0, 1)));
                    mem_phase(5, wm, err);
                end
                T_R:    begin drive_cycle(6, 1'b1); drive_cycle(7, 1'b0); end
                T_ADDI: begin drive_cycle(8, 1'b0); drive_cycle(9, 1'b1); end
                T_BEQ:  drive_cycle(10, 1'($urandom_range(0, 1)));
                T_J:    drive_cycle(11, 1'($urandom_range(0, 1)));
                default: drive_cycle(12, 1'($urandom_range(0, 1)));
            endcase
        end
        if (err) begin
            for (int i = 0; i < 3; i++) drive_cycle(13, 1'($urandom_range(0, 1)));
            async_reset("bus_err");
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return r % 3;
        if (r < 17) return TB_MAX_WAIT;
        return TB_MAX_WAIT + 1 + (r % 3);
    endfunction

    initial begin
        logic [5:0] op;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'd0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", sample_dut(), '0);
        reset = 1'b0;

        applyStimulus(T_R, 0, 0);
        applyStimulus(T_LW, 0, 3);
        applyStimulus(T_BEQ, 0, 0);
        applyStimulus(T_J, 0, 0);
        applyStimulus(6'b111111, 0, 0);
        applyStimulus(T_ADDI, 2, 0);
        applyStimulus(T_SW, 1, 3);
        applyStimulus(T_R, 4, 0);
        applyStimulus(T_LW, 0, 4);

        // Abort a store mid-access; the next instruction's fetch is checked normally.
        opcode = T_SW;
        drive_cycle(0, 1'b1);
        drive_cycle(1, 1'b0);
        drive_cycle(2, 1'b1);
        drive_cycle(5, 1'b0);
        async_reset("mem_wr");
        applyStimulus(T_R, 0, 0);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 6))
                0: op = T_R;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                4: op = T_J;
                5: op = T_ADDI;
                default: begin
                    do op = 6'($urandom);
                    while (op == T_R || op == T_LW || op == T_SW ||
                           op == T_BEQ || op == T_J || op == T_ADDI);
                end
            endcase
            applyStimulus(op, rand_wait(), rand_wait());
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle main decoder. A Moore/Mealy FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback, and drives the shared-datapath strobes. It handshakes with a variable-latency unified memory, with an optional timeout. It sits between the instruction register / opcode field and the multi-cycle datapath muxes, ALU control and register file.

Parameters:
OPCODE_W, 6, opcode width (instruction[31:26])
ALUOP_W, 2, width of alu_op to the ALU-control block
MAX_WAIT, 15, max cycles with mem_ready low in a memory state before bus error; 0 disables the timeout
WAIT_W, 4, wait-counter width; must hold MAX_WAIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward
zero  in  1  ALU zero flag; used only in BRANCH
mem_ready  in  1  memory completes the current read/write this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load the instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero (beq)
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = funct-decode
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
reg_dst  out  1  0 = rt, 1 = rd
reg_write  out  1  register-file write enable
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal_op  out  1  one-cycle pulse on an unsupported opcode
bus_error  out  1  sticky; set on memory timeout
state  out  4  current state code, for debug and the bench

Behaviour:
- Reset (async, active-high): state = FETCH, wait counter = 0, bus_error = 0. Every strobe is 0 while reset is held.
- Strobes not listed for a state are 0.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- State codes:
  - 0 FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write and pc_write equal mem_ready (Mealy). Stay while !mem_ready, else go to DECODE.
  - 1 DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state: lw/sw go to MEM_ADDR; R goes to EXEC_R; addi goes to EXEC_I; beq goes to BRANCH; j goes to JUMP; any other opcode goes to TRAP.
  - 2 MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_RD for lw, MEM_WR for sw.
  - 3 MEM_RD: mem_read = 1, i_or_d = 1. Wait for mem_ready, then go to WB_MEM.
  - 4 WB_MEM: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH.
  - 5 MEM_WR: mem_write = 1, i_or_d = 1. Wait for mem_ready, then go to FETCH.
  - 6 EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to WB_R.
  - 7 WB_R: reg_dst = 1, reg_write = 1, mem_to_reg = 0. Go to FETCH.
  - 8 EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to WB_I.
  - 9 WB_I: reg_dst = 0, reg_write = 1, mem_to_reg = 0. Go to FETCH.
  - 10 BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Go to FETCH. The zero flag is consumed by the datapath.
  - 11 JUMP: pc_write = 1, pc_source = 10. Go to FETCH.
  - 12 TRAP: illegal_op = 1 for exactly one cycle, then FETCH. PC has already advanced, so the instruction is skipped.
  - 13 BUS_ERR: bus_error = 1, all strobes 0. Terminal until reset.
- Latency per instruction (mem_ready=1 on first request): R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready = 0, saturating at MAX_WAIT.
  - If MAX_WAIT != 0, counter == MAX_WAIT and mem_ready = 0, the next state is BUS_ERR.
  - mem_ready = 1 in the same cycle as the limit is reached wins; the normal transition is taken.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-instruction aborts immediately to FETCH; no partial writeback strobe is emitted.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the opcode localparams,
  - the state encoding (4-bit enum/localparams),
  - the ALUOP, alu_src_b and pc_source codes.
- One sub-module, mem_wait_timer (counter plus timeout compare, parameterised by MAX_WAIT/WAIT_W).
- The FSM next-state and output decode stay in the top.

Test Plan:
- R-type (opcode 000000), mem_ready held 1 → states 0,1,6,7,0. In WB_R: reg_dst = 1, reg_write = 1, alu_op stayed 10 in EXEC_R. Total 4 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles, then WB_MEM with mem_to_reg = 1, reg_write = 1. No bus_error.
- beq/j back-to-back → BRANCH shows pc_write_cond = 1, pc_source = 01, alu_op = 01. JUMP shows pc_write = 1, pc_source = 10. Each takes 3 cycles.
- Opcode 111111 → DECODE, then TRAP with illegal_op high exactly 1 cycle, then FETCH. reg_write and mem_write stay 0 throughout.
- MAX_WAIT = 3, mem_ready stuck 0 in FETCH → BUS_ERR after 4 FETCH cycles, bus_error = 1 sticky. Async reset clears it to FETCH without waiting for a clock edge.
- Reset pulse during MEM_WR → mem_write drops asynchronously and state = 0. The first post-reset cycle asserts mem_read with i_or_d = 0.
